pong_match_ctrl: RTL and testbench

//  Match sequencer for the Pong datapath: owns the serve/play/point/level/game-over flow.

---
 rtl/pong_pkg.sv | 22 ++
 rtl/match_timer.sv | 26 ++
 rtl/pong_match_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong constants: match FSM encoding, score/level widths and round limits.
package pong_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SCORE_W = 3;
    localparam int unsigned LEVEL_W = 3;
    localparam int unsigned WINNER_W = 2;

    localparam int unsigned WIN_SCORE_DEF = 7;
    localparam int unsigned MAX_LEVEL_DEF = 7;

    typedef logic [STATE_W-1:0] match_state_t;

    localparam match_state_t ST_IDLE  = 3'd0;
    localparam match_state_t ST_SERVE = 3'd1;
    localparam match_state_t ST_PLAY  = 3'd2;
    localparam match_state_t ST_PAUSE = 3'd3;
    localparam match_state_t ST_POINT = 3'd4;
    localparam match_state_t ST_LEVEL = 3'd5;
    localparam match_state_t ST_OVER  = 3'd6;

endpackage

// File: rtl/match_timer.sv
// Loadable down-counter that parks at zero; shared by the serve and point delays.
module match_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/pause/point/level/game-over flow driving ball,
// paddles, score clear, level and audio pulses.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE = WIN_SCORE_DEF,
    parameter int unsigned MAX_LEVEL = MAX_LEVEL_DEF,
    parameter int unsigned SERVE_DLY = 25_000_000,
    parameter int unsigned POINT_DLY = 50_000_000,
    parameter int unsigned CNT_W     = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_sw,
    input  logic                pause_sw,
    input  logic                p1_point,
    input  logic                p2_point,
    input  logic [SCORE_W-1:0]  p1_total,
    input  logic [SCORE_W-1:0]  p2_total,
    output logic                ball_run,
    output logic                round_rst_n,
    output logic                score_clr,
    output logic [LEVEL_W-1:0]  level,
    output logic                lvl_up,
    output logic                win,
    output logic [WINNER_W-1:0] winner,
    output logic [STATE_W-1:0]  state_o
);

    logic start_m, start_s, start_s_d;
    logic pause_m, pause_s;

    match_state_t state_q, state_d;

    logic                score_clr_d, lvl_up_d, win_d;
    logic                ball_run_d, round_rst_n_d;
    logic [LEVEL_W-1:0]  level_d;
    logic [WINNER_W-1:0] winner_d;

    logic             start_edge_c;
    logic             p1_win_c, p2_win_c;
    logic             timer_load_c;
    logic [CNT_W-1:0] timer_val_c;
    logic             timer_zero_c;

    // Two-flop synchronisers plus a delayed copy of start for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_m   <= 1'b0;
            start_s   <= 1'b0;
            start_s_d <= 1'b0;
            pause_m   <= 1'b0;
            pause_s   <= 1'b0;
        end else begin
            start_m   <= start_sw;
            start_s   <= start_m;
            start_s_d <= start_s;
            pause_m   <= pause_sw;
            pause_s   <= pause_m;
        end
    end

    assign start_edge_c = start_s & ~start_s_d;
    assign p1_win_c     = (p1_total >= SCORE_W'(WIN_SCORE));
    assign p2_win_c     = (p2_total >= SCORE_W'(WIN_SCORE));

    always_comb begin
        state_d     = state_q;
        score_clr_d = 1'b0;
        lvl_up_d    = 1'b0;
        win_d       = 1'b0;
        level_d     = level;
        winner_d    = winner;

        case (state_q)
            ST_IDLE: begin
                if (start_edge_c) begin
                    score_clr_d = 1'b1;
                    level_d     = '0;
                    winner_d    = '0;
                    state_d     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!start_s)          state_d = ST_IDLE;
                else if (timer_zero_c) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (!start_s)                  state_d = ST_IDLE;
                else if (p1_point || p2_point) state_d = ST_POINT;
                else if (pause_s)              state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (!start_s)      state_d = ST_IDLE;
                else if (!pause_s) state_d = ST_PLAY;
            end
            ST_POINT: begin
                // Totals have settled by the time the freeze expires
                if (!start_s) begin
                    state_d = ST_IDLE;
                end else if (timer_zero_c) begin
                    if (p1_win_c || p2_win_c) begin
                        winner_d = {p2_win_c, p1_win_c};
                        win_d    = 1'b1;
                        state_d  = (level < LEVEL_W'(MAX_LEVEL)) ? ST_LEVEL : ST_OVER;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_LEVEL: begin
                if (!start_s) begin
                    state_d = ST_IDLE;
                end else begin
                    if (level < LEVEL_W'(MAX_LEVEL)) level_d = level + LEVEL_W'(1);
                    lvl_up_d    = 1'b1;
                    score_clr_d = 1'b1;
                    state_d     = ST_SERVE;
                end
            end
            ST_OVER: begin
                if (!start_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from the next state so they line up with state_o
    assign ball_run_d    = (state_d == ST_PLAY);
    assign round_rst_n_d = (state_d == ST_PLAY) || (state_d == ST_PAUSE) || (state_d == ST_POINT);
    assign timer_load_c  = (state_d != state_q) && ((state_d == ST_SERVE) || (state_d == ST_POINT));
    assign timer_val_c   = (state_d == ST_SERVE) ? CNT_W'(SERVE_DLY - 1) : CNT_W'(POINT_DLY - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ball_run    <= 1'b0;
            round_rst_n <= 1'b0;
            score_clr   <= 1'b0;
            level       <= '0;
            lvl_up      <= 1'b0;
            win         <= 1'b0;
            winner      <= '0;
        end else begin
            state_q     <= state_d;
            ball_run    <= ball_run_d;
            round_rst_n <= round_rst_n_d;
            score_clr   <= score_clr_d;
            level       <= level_d;
            lvl_up      <= lvl_up_d;
            win         <= win_d;
            winner      <= winner_d;
        end
    end

    assign state_o = state_q;

    match_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load_c),
        .load_val(timer_val_c),
        .zero_c  (timer_zero_c)
    );

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with short serve/point delays and MAX_LEVEL=2.
module tb_pong_match_ctrl;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_POINT = 3'd4;
    localparam logic [2:0] S_LEVEL = 3'd5;
    localparam logic [2:0] S_OVER  = 3'd6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_sw = 1'b0;
    logic       pause_sw = 1'b0;
    logic       p1_point = 1'b0;
    logic       p2_point = 1'b0;
    logic [2:0] p1_total = 3'd0;
    logic [2:0] p2_total = 3'd0;
    logic       ball_run, round_rst_n, score_clr, lvl_up, win;
    logic [2:0] level;
    logic [1:0] winner;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    pong_match_ctrl #(
        .WIN_SCORE(7),
        .MAX_LEVEL(2),
        .SERVE_DLY(4),
        .POINT_DLY(6),
        .CNT_W    (26)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_sw   (start_sw),
        .pause_sw   (pause_sw),
        .p1_point   (p1_point),
        .p2_point   (p2_point),
        .p1_total   (p1_total),
        .p2_total   (p2_total),
        .ball_run   (ball_run),
        .round_rst_n(round_rst_n),
        .score_clr  (score_clr),
        .level      (level),
        .lvl_up     (lvl_up),
        .win        (win),
        .winner     (winner),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle point pulse with the totals the score block would present
    task automatic fire_point(input logic a, input logic b, input logic [2:0] t1, input logic [2:0] t2);
        p1_point = a; p2_point = b; p1_total = t1; p2_total = t2;
        cyc(1);
        p1_point = 1'b0; p2_point = 1'b0;
    endtask

    task automatic test_reset();
        cyc(2);
        checks++;
        if ({state_o, ball_run, round_rst_n, score_clr, level, lvl_up, win, winner} !== 13'd0) begin
            errors++;
            $display("FAIL reset_values: got %h want 0", {state_o, ball_run, round_rst_n, score_clr, level, lvl_up, win, winner});
        end
    endtask

    task automatic test_start();
        reset = 1'b1; start_sw = 1'b1;
        cyc(2);
        checks++;
        if ({state_o, score_clr} !== {S_IDLE, 1'b0}) begin
            errors++; $display("FAIL start_sync_lag: got %h want %h", {state_o, score_clr}, {S_IDLE, 1'b0});
        end
        cyc(1);
        checks++;
        if ({state_o, score_clr, ball_run, round_rst_n, level} !== {S_SERVE, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            errors++; $display("FAIL start_serve_clr: got %h want %h", {state_o, score_clr, ball_run, round_rst_n, level}, {S_SERVE, 1'b1, 1'b0, 1'b0, 3'd0});
        end
        cyc(1);
        checks++;
        if ({state_o, score_clr} !== {S_SERVE, 1'b0}) begin
            errors++; $display("FAIL start_clr_one_cycle: got %h want %h", {state_o, score_clr}, {S_SERVE, 1'b0});
        end
        cyc(2);
        checks++;
        if (state_o !== S_SERVE) begin
            errors++; $display("FAIL serve_last_cycle: got %0d want %0d", state_o, S_SERVE);
        end
        cyc(1);
        checks++;
        if ({state_o, ball_run, round_rst_n} !== {S_PLAY, 1'b1, 1'b1}) begin
            errors++; $display("FAIL start_play: got %h want %h", {state_o, ball_run, round_rst_n}, {S_PLAY, 1'b1, 1'b1});
        end
    endtask

    task automatic test_point_no_win();
        fire_point(1'b1, 1'b0, 3'd3, 3'd0);
        checks++;
        if ({state_o, ball_run, round_rst_n} !== {S_POINT, 1'b0, 1'b1}) begin
            errors++; $display("FAIL point_entry: got %h want %h", {state_o, ball_run, round_rst_n}, {S_POINT, 1'b0, 1'b1});
        end
        cyc(5);
        checks++;
        if ({state_o, win} !== {S_POINT, 1'b0}) begin
            errors++; $display("FAIL point_hold: got %h want %h", {state_o, win}, {S_POINT, 1'b0});
        end
        cyc(1);
        checks++;
        if ({state_o, win, lvl_up, score_clr, round_rst_n} !== {S_SERVE, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL point_to_serve: got %h want %h", {state_o, win, lvl_up, score_clr, round_rst_n}, {S_SERVE, 4'b0});
        end
        cyc(4);
        checks++;
        if (state_o !== S_PLAY) begin
            errors++; $display("FAIL point_replay: got %0d want %0d", state_o, S_PLAY);
        end
    endtask

    task automatic test_win_level();
        fire_point(1'b0, 1'b1, 3'd0, 3'd7);
        cyc(5);
        checks++;
        if ({state_o, win} !== {S_POINT, 1'b0}) begin
            errors++; $display("FAIL win_point_hold: got %h want %h", {state_o, win}, {S_POINT, 1'b0});
        end
        cyc(1);
        checks++;
        if ({state_o, win, winner, level, lvl_up} !== {S_LEVEL, 1'b1, 2'b10, 3'd0, 1'b0}) begin
            errors++; $display("FAIL win_pulse: got %h want %h", {state_o, win, winner, level, lvl_up}, {S_LEVEL, 1'b1, 2'b10, 3'd0, 1'b0});
        end
        cyc(1);
        checks++;
        if ({state_o, win, lvl_up, score_clr, level} !== {S_SERVE, 1'b0, 1'b1, 1'b1, 3'd1}) begin
            errors++; $display("FAIL level_up: got %h want %h", {state_o, win, lvl_up, score_clr, level}, {S_SERVE, 1'b0, 1'b1, 1'b1, 3'd1});
        end
        p1_total = 3'd0; p2_total = 3'd0;
        cyc(1);
        checks++;
        if ({lvl_up, score_clr, winner} !== {1'b0, 1'b0, 2'b10}) begin
            errors++; $display("FAIL level_pulses_end: got %h want %h", {lvl_up, score_clr, winner}, {1'b0, 1'b0, 2'b10});
        end
        cyc(3);
        checks++;
        if (state_o !== S_PLAY) begin
            errors++; $display("FAIL level_replay: got %0d want %0d", state_o, S_PLAY);
        end
    endtask

    task automatic test_max_level();
        fire_point(1'b1, 1'b0, 3'd7, 3'd0);
        cyc(6);
        checks++;
        if ({state_o, win, winner} !== {S_LEVEL, 1'b1, 2'b01}) begin
            errors++; $display("FAIL win_lvl1: got %h want %h", {state_o, win, winner}, {S_LEVEL, 1'b1, 2'b01});
        end
        cyc(1);
        checks++;
        if ({level, lvl_up} !== {3'd2, 1'b1}) begin
            errors++; $display("FAIL level_two: got %h want %h", {level, lvl_up}, {3'd2, 1'b1});
        end
        p1_total = 3'd0;
        cyc(4);
        fire_point(1'b1, 1'b0, 3'd7, 3'd0);
        cyc(6);
        checks++;
        if ({state_o, win, level, lvl_up} !== {S_OVER, 1'b1, 3'd2, 1'b0}) begin
            errors++; $display("FAIL max_win_over: got %h want %h", {state_o, win, level, lvl_up}, {S_OVER, 1'b1, 3'd2, 1'b0});
        end
        cyc(1);
        checks++;
        if ({state_o, win, lvl_up, score_clr, ball_run, round_rst_n, level} !== {S_OVER, 5'b0, 3'd2}) begin
            errors++; $display("FAIL over_hold: got %h want %h", {state_o, win, lvl_up, score_clr, ball_run, round_rst_n, level}, {S_OVER, 5'b0, 3'd2});
        end
        p1_total = 3'd0; start_sw = 1'b0;
        cyc(2);
        checks++;
        if (state_o !== S_OVER) begin
            errors++; $display("FAIL over_sync_lag: got %0d want %0d", state_o, S_OVER);
        end
        cyc(1);
        checks++;
        if ({state_o, level, winner} !== {S_IDLE, 3'd2, 2'b01}) begin
            errors++; $display("FAIL over_to_idle: got %h want %h", {state_o, level, winner}, {S_IDLE, 3'd2, 2'b01});
        end
        start_sw = 1'b1;
        cyc(3);
        checks++;
        if ({state_o, score_clr, level, winner} !== {S_SERVE, 1'b1, 3'd0, 2'b00}) begin
            errors++; $display("FAIL restart_clear: got %h want %h", {state_o, score_clr, level, winner}, {S_SERVE, 1'b1, 3'd0, 2'b00});
        end
        cyc(4);
        checks++;
        if (state_o !== S_PLAY) begin
            errors++; $display("FAIL restart_play: got %0d want %0d", state_o, S_PLAY);
        end
    endtask

    task automatic test_pause();
        pause_sw = 1'b1;
        cyc(2);
        checks++;
        if (state_o !== S_PLAY) begin
            errors++; $display("FAIL pause_sync_lag: got %0d want %0d", state_o, S_PLAY);
        end
        cyc(1);
        checks++;
        if ({state_o, ball_run, round_rst_n} !== {S_PAUSE, 1'b0, 1'b1}) begin
            errors++; $display("FAIL pause_entry: got %h want %h", {state_o, ball_run, round_rst_n}, {S_PAUSE, 1'b0, 1'b1});
        end
        fire_point(1'b1, 1'b0, 3'd7, 3'd0);
        cyc(2);
        checks++;
        if ({state_o, win} !== {S_PAUSE, 1'b0}) begin
            errors++; $display("FAIL pause_ignores_point: got %h want %h", {state_o, win}, {S_PAUSE, 1'b0});
        end
        p1_total = 3'd0; pause_sw = 1'b0;
        cyc(3);
        checks++;
        if ({state_o, ball_run} !== {S_PLAY, 1'b1}) begin
            errors++; $display("FAIL unpause: got %h want %h", {state_o, ball_run}, {S_PLAY, 1'b1});
        end
        pause_sw = 1'b1;
        cyc(2);
        fire_point(1'b1, 1'b0, 3'd3, 3'd0);
        checks++;
        if (state_o !== S_POINT) begin
            errors++; $display("FAIL pause_point_same: got %0d want %0d", state_o, S_POINT);
        end
        pause_sw = 1'b0;
        cyc(6);
        checks++;
        if ({state_o, win} !== {S_SERVE, 1'b0}) begin
            errors++; $display("FAIL pause_point_serve: got %h want %h", {state_o, win}, {S_SERVE, 1'b0});
        end
        cyc(4);
    endtask

    task automatic test_draw_abort();
        fire_point(1'b1, 1'b1, 3'd7, 3'd7);
        checks++;
        if (state_o !== S_POINT) begin
            errors++; $display("FAIL draw_point: got %0d want %0d", state_o, S_POINT);
        end
        cyc(6);
        checks++;
        if ({state_o, win, winner} !== {S_LEVEL, 1'b1, 2'b11}) begin
            errors++; $display("FAIL draw_win: got %h want %h", {state_o, win, winner}, {S_LEVEL, 1'b1, 2'b11});
        end
        cyc(1);
        checks++;
        if ({win, lvl_up, level} !== {1'b0, 1'b1, 3'd1}) begin
            errors++; $display("FAIL draw_single_win: got %h want %h", {win, lvl_up, level}, {1'b0, 1'b1, 3'd1});
        end
        p1_total = 3'd0; p2_total = 3'd0;
        cyc(4);
        start_sw = 1'b0;
        fire_point(1'b1, 1'b0, 3'd7, 3'd0);
        cyc(1);
        checks++;
        if (state_o !== S_POINT) begin
            errors++; $display("FAIL abort_lag: got %0d want %0d", state_o, S_POINT);
        end
        cyc(1);
        checks++;
        if ({state_o, lvl_up, win, score_clr, ball_run, round_rst_n, level, winner} !== {S_IDLE, 5'b0, 3'd1, 2'b11}) begin
            errors++; $display("FAIL abort_idle: got %h want %h", {state_o, lvl_up, win, score_clr, ball_run, round_rst_n, level, winner}, {S_IDLE, 5'b0, 3'd1, 2'b11});
        end
        cyc(6);
        checks++;
        if ({state_o, lvl_up, win, score_clr} !== {S_IDLE, 3'b0}) begin
            errors++; $display("FAIL abort_no_pulse: got %h want %h", {state_o, lvl_up, win, score_clr}, {S_IDLE, 3'b0});
        end
    endtask

    task automatic test_async_reset();
        start_sw = 1'b1;
        cyc(3);
        checks++;
        if ({state_o, score_clr} !== {S_SERVE, 1'b1}) begin
            errors++; $display("FAIL pre_reset_serve: got %h want %h", {state_o, score_clr}, {S_SERVE, 1'b1});
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({state_o, ball_run, round_rst_n, score_clr, level, lvl_up, win, winner} !== 13'd0) begin
            errors++; $display("FAIL async_reset: got %h want 0", {state_o, ball_run, round_rst_n, score_clr, level, lvl_up, win, winner});
        end
        cyc(2);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_start();
        test_point_no_win();
        test_win_level();
        test_max_level();
        test_pause();
        test_draw_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
